instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch stage and IF/ID pipeline register of the 5-stage pipelined processor. It holds the program counter, addresses the combinational instruction memory, and delivers `InstrD` and `PCPlus8D` to the decode-stage controller and register file. It redirects the PC on an execute-stage branch (`BranchTakenE`) or a writeback-stage R15 write (`PCSrcW`). It obeys the hazard unit's stall and flush controls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `WIDTH`, default 32: address and instruction width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `StallF` in 1: hold the PC (load-use stall from the hazard unit).
- `StallD` in 1: hold the IF/ID register.
- `FlushD` in 1: replace the IF/ID contents with a bubble.
- `BranchTakenE` in 1: execute-stage branch resolved taken.
- `ALUResultE` in 32: branch target computed in the execute stage.
- `PCSrcW` in 1: writeback stage is writing R15.
- `ResultW` in 32: value written back to R15.
- `ImemRdata` in 32: instruction memory read data, combinational from `PCF`.
- `PCF` out 32: current fetch address; also drives the instruction memory address.
- `PCPlus4F` out 32: `PCF + 4`.
- `InstrD` out 32: decode-stage instruction.
- `PCPlus8D` out 32: R15 read value for the decode-stage instruction.
- `FetchCntO` out 32, present only with `INSTR_FETCH_PERF_EN`: count of instructions accepted into decode.
- `BubbleCntO` out 32, present only with `INSTR_FETCH_PERF_EN`: count of bubbles inserted into decode.

## Operation
- Next-PC selection, highest priority first:
  1. `BranchTakenE` → `ALUResultE`
  2. `PCSrcW` → `ResultW`
  3. otherwise `PCPlus4F`
- PC register update:
  - Loads on every edge when `StallF`=0.
  - A redirect (`BranchTakenE` or `PCSrcW` = 1) loads the PC even when `StallF`=1. Redirects are never lost.
  - With `StallF`=1 and no redirect, the PC holds.
- IF/ID register, holding `InstrD` and `PCD`:
  - `FlushD`=1 → `InstrD` ← `NOP_INSTR` (32'hFC00_0000: cond=1111, op=11; decodes to all-zero control and a false condition). `PCD` ← 0. `FlushD` overrides `StallD`.
  - `StallD`=1 and `FlushD`=0 → hold.
  - Otherwise → `InstrD` ← `ImemRdata`, `PCD` ← `PCF`.
- `PCPlus8D` = `PCD + 8`, combinational from the registered `PCD`.
- Arithmetic: all additions are modulo 2^32. `PCF` = 32'hFFFF_FFFC wraps to 0 with no error. The low two bits of redirect targets pass through unmodified; alignment is software's responsibility.
- Reset mid-operation:
  - `PCF` ← `RESET_PC` immediately.
  - `InstrD` ← `NOP_INSTR`, `PCD` ← 0.
  - A pending redirect is discarded.

## Timing
- Reset values:
  - `PCF` = `RESET_PC`, `PCPlus4F` = `RESET_PC`+4.
  - `InstrD` = 32'hFC00_0000, `PCPlus8D` = 8.
  - Both counters = 0.
- Fetch latency: the instruction at `PCF` appears on `InstrD` one edge later, unless stalled or flushed.
- Redirect latency: a redirect asserted in cycle N gives `PCF` = target in cycle N+1. The wrong-path instruction is removed only if the hazard unit asserts `FlushD` in cycle N, as required by the hazard unit spec.
- Simultaneous `BranchTakenE` and `PCSrcW`: the branch target wins.
- Combinational paths:
  - `ImemRdata` → `InstrD` D-input only.
  - Redirect inputs → PC D-input only.
  - No input reaches an output without passing through a register, except `PCPlus4F` from `PCF`.

## Configuration
- `INSTR_FETCH_PERF_EN` defined:
  - `FetchCntO` increments on each edge where the IF/ID register loads `ImemRdata`.
  - `BubbleCntO` increments on each edge where `FlushD`=1.
  - Both counters are 32-bit, wrap to 0, and reset to 0.
- `INSTR_FETCH_PERF_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- The shared `pipeline_defs` include holds:
  - `NOP_INSTR` (32'hFC00_0000)
  - default `RESET_PC`
  - the PC-increment constants (4, 8)
- The controller also uses `NOP_INSTR` for its bubble checks.
- One sub-module, `pipe_reg_en_clr`:
  - Parameterised `WIDTH`; asynchronous reset to parameter `RST_VAL`.
  - Active-high enable; synchronous clear to parameter `CLR_VAL`, where clear beats enable.
  - Used for the PC register and for both IF/ID fields.

## Test plan
- Reset, then release with no stalls, memory returning 32'hE280_0001 at every address:
  - `PCF` steps 0, 4, 8, C.
  - `InstrD` = NOP in the first cycle, 32'hE280_0001 afterwards.
  - `PCPlus8D` = 8, 8, C, 10.
- `StallF`=`StallD`=1 for 2 cycles at `PCF`=8: `PCF` stays 8, `InstrD`/`PCPlus8D` hold, then resume at C.
- `BranchTakenE`=1, `ALUResultE`=32'h40 together with `FlushD`=1:
  - Next cycle `PCF`=40 and `InstrD`=32'hFC00_0000.
  - One cycle later `InstrD` = mem[40] and `PCPlus8D`=48.
- `BranchTakenE`=1 (32'h100) and `PCSrcW`=1 (32'h200) in the same cycle: `PCF`=100. Repeat with `StallF`=1: `PCF`=100.
- `PCF`=32'hFFFF_FFFC with no redirect: next `PCF`=0 and `PCPlus4F`=4. `reset` asserted mid-stall: `PCF`=`RESET_PC` asynchronously, before the next edge.
- With `INSTR_FETCH_PERF_EN`: 10 normal fetches, 2 flushes and 1 stall cycle give `FetchCntO`=10 and `BubbleCntO`=2.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared pipeline definitions: bubble encoding, default reset PC and PC increments.
// Imported by the fetch stage and by the decode-stage controller for its bubble checks.
package instr_fetch_pkg;

    // cond=1111, op=11: decodes to all-zero control with a false condition
    localparam logic [31:0] NOP_INSTR        = 32'hFC00_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC4          = 32'd4;
    localparam logic [31:0] PC_INC8          = 32'd8;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with asynchronous reset, active-high enable and synchronous clear.
// Clear takes priority over enable.
module pipe_reg_en_clr #(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State update: reset, then clear, then enabled load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage plus IF/ID pipeline register.
// Optional build macro INSTR_FETCH_PERF_EN adds fetch and bubble counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] ImemRdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] InstrD,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0]      FetchCntO,
    output logic [31:0]      BubbleCntO,
`endif
    output logic [WIDTH-1:0] PCPlus8D
);

    logic [WIDTH-1:0] pc_next;
    logic             pc_en;
    logic             ifid_en;
    logic [WIDTH-1:0] pcd;

    // Next-PC select: branch beats R15 write beats sequential; redirects override StallF
    always_comb begin
        pc_next = PCPlus4F;
        if (BranchTakenE) begin
            pc_next = ALUResultE;
        end else if (PCSrcW) begin
            pc_next = ResultW;
        end
        pc_en   = ~StallF | BranchTakenE | PCSrcW;
        ifid_en = ~StallD;
    end

    pipe_reg_en_clr #(
        .WIDTH   (WIDTH),
        .RST_VAL (RESET_PC),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (reset),
        .en  (pc_en),
        .clr (1'b0),
        .d   (pc_next),
        .q   (PCF)
    );

    pipe_reg_en_clr #(
        .WIDTH   (WIDTH),
        .RST_VAL (WIDTH'(NOP_INSTR)),
        .CLR_VAL (WIDTH'(NOP_INSTR))
    ) u_instr_reg (
        .clk (clk),
        .rst (reset),
        .en  (ifid_en),
        .clr (FlushD),
        .d   (ImemRdata),
        .q   (InstrD)
    );

    pipe_reg_en_clr #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_pcd_reg (
        .clk (clk),
        .rst (reset),
        .en  (ifid_en),
        .clr (FlushD),
        .d   (PCF),
        .q   (pcd)
    );

    // PC increments, modulo 2^WIDTH
    always_comb begin
        PCPlus4F = PCF + WIDTH'(PC_INC4);
        PCPlus8D = pcd + WIDTH'(PC_INC8);
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    // Count IF/ID loads of fresh instructions and inserted bubbles; both wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (FlushD) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end else if (!StallD) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign FetchCntO  = fetch_cnt;
    assign BubbleCntO = bubble_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios plus randomized pipeline controls,
// checked against a cycle-level behavioural model of the fetch stage.
module tb_instr_fetch;

    localparam logic [31:0] NOP    = 32'hFC00_0000;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pcp4;
        logic [31:0] instr;
        logic [31:0] pcp8;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW, ImemRdata;
    logic [31:0] PCF, PCPlus4F, InstrD, PCPlus8D;
    logic [31:0] fc_dut, bc_dut;

    int checks   = 0;
    int failures = 0;
    bit const_mem = 1'b0;

    exp_t q[$];

    // model state
    logic [31:0] m_pc, m_instr, m_pcd, m_fc, m_bc;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .ImemRdata    (ImemRdata),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .InstrD       (InstrD),
`ifdef INSTR_FETCH_PERF_EN
        .FetchCntO    (fc_dut),
        .BubbleCntO   (bc_dut),
`endif
        .PCPlus8D     (PCPlus8D)
    );

`ifndef INSTR_FETCH_PERF_EN
    assign fc_dut = 32'd0;
    assign bc_dut = 32'd0;
`endif

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (const_mem) return 32'hE280_0001;
        return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign ImemRdata = mem(PCF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_instr = NOP;
        m_pcd   = 32'd0;
        m_fc    = 32'd0;
        m_bc    = 32'd0;
    endtask

    task automatic check_now(input string tag);
        chk({tag, "_pcf"}, PCF, m_pc);
        chk({tag, "_pcp4"}, PCPlus4F, m_pc + 32'd4);
        chk({tag, "_instr"}, InstrD, m_instr);
        chk({tag, "_pcp8"}, PCPlus8D, m_pcd + 32'd8);
`ifdef INSTR_FETCH_PERF_EN
        chk({tag, "_fcnt"}, fc_dut, m_fc);
        chk({tag, "_bcnt"}, bc_dut, m_bc);
`endif
    endtask

    // Apply one cycle of controls (called at negedge+1), advance the model, queue the expectation
    task automatic step(input bit sf, input bit sd, input bit fd, input bit br,
                        input logic [31:0] alu, input bit ps, input logic [31:0] res);
        exp_t e;
        StallF = sf; StallD = sd; FlushD = fd;
        BranchTakenE = br; ALUResultE = alu; PCSrcW = ps; ResultW = res;
        if (fd) begin
            m_instr = NOP;
            m_pcd   = 32'd0;
            m_bc    = m_bc + 32'd1;
        end else if (!sd) begin
            m_instr = mem(m_pc);
            m_pcd   = m_pc;
            m_fc    = m_fc + 32'd1;
        end
        if (br)       m_pc = alu;
        else if (ps)  m_pc = res;
        else if (!sf) m_pc = m_pc + 32'd4;
        e.pcf = m_pc; e.pcp4 = m_pc + 32'd4; e.instr = m_instr; e.pcp8 = m_pcd + 32'd8;
        e.fc = m_fc; e.bc = m_bc;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run_normal(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    // Monitor: compare DUT outputs against queued expectations just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcf", PCF, e.pcf);
                chk("pcplus4f", PCPlus4F, e.pcp4);
                chk("instrd", InstrD, e.instr);
                chk("pcplus8d", PCPlus8D, e.pcp8);
`ifdef INSTR_FETCH_PERF_EN
                chk("fetchcnt", fc_dut, e.fc);
                chk("bubblecnt", bc_dut, e.bc);
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
        ALUResultE = '0; ResultW = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_now("reset");
        reset = 1'b0;

        // straight-line fetch with constant memory, then 2-cycle stall at PCF=8
        const_mem = 1'b1;
        run_normal(2);
        step(1, 1, 0, 0, 32'd0, 0, 32'd0);
        step(1, 1, 0, 0, 32'd0, 0, 32'd0);
        run_normal(2);
        const_mem = 1'b0;

        // branch with flush, then fetch from target
        step(0, 0, 1, 1, 32'h40, 0, 32'd0);
        run_normal(2);

        // simultaneous redirects, with and without StallF
        step(0, 0, 0, 1, 32'h100, 1, 32'h200);
        step(1, 1, 0, 1, 32'h100, 1, 32'h200);
        step(1, 0, 0, 0, 32'd0, 1, 32'h300);
        run_normal(1);

        // wrap-around from the top of the address space
        step(0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC);
        run_normal(3);

        // perf scenario: 10 fetches, 2 flushes, 1 stall
        run_normal(5);
        step(0, 0, 1, 0, 32'd0, 0, 32'd0);
        step(0, 1, 0, 0, 32'd0, 0, 32'd0);
        step(0, 0, 1, 0, 32'd0, 0, 32'd0);
        run_normal(5);

        // randomized control traffic
        for (int i = 0; i < 500; i++) begin
            bit sf, sd, fd, br, ps;
            logic [31:0] alu, res;
            sf = ($urandom_range(3) == 0);
            sd = sf ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
            fd = ($urandom_range(4) == 0);
            br = ($urandom_range(5) == 0);
            ps = ($urandom_range(7) == 0);
            alu = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom();
            res = $urandom();
            step(sf, sd, fd, br, alu, ps, res);
        end

        // asynchronous reset while stalled with a pending redirect
        StallF = 1; StallD = 1; BranchTakenE = 1; ALUResultE = 32'h1234_5678;
        reset = 1'b1;
        model_reset();
        #1;
        check_now("async_reset");
        @(negedge clk);
        #1;
        check_now("reset_hold");
        StallF = 0; StallD = 0; BranchTakenE = 0;
        reset = 1'b0;
        run_normal(4);
        for (int i = 0; i < 50; i++) begin
            step($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
                 $urandom_range(5) == 0, $urandom(), $urandom_range(5) == 0, $urandom());
        end
        run_normal(1);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
